// File: rtl/wbs_patch_loader.sv
// Wishbone master that streams query patches into the query-patch memory,
// writing each patch as a lower and an upper 32-bit beat.
module wbs_patch_loader #(
    parameter int          DATA_WIDTH     = 11,
    parameter int          PATCH_SIZE     = 5,
    parameter int          ROW_SIZE       = 24,
    parameter int          COL_SIZE       = 17,
    parameter int          NUM_QUERYS     = ROW_SIZE * COL_SIZE,
    parameter logic [31:0] BASE_ADDR      = 32'h3100_0000,
    parameter int          TIMEOUT_CYCLES = 255,
    localparam int         AW             = $clog2(NUM_QUERYS),
    localparam int         CW             = $clog2(NUM_QUERYS) + 1,
    localparam int         PW             = PATCH_SIZE * DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [CW-1:0] num_patches,
    input  logic          patch_valid,
    input  logic [PW-1:0] patch_data,
    output logic          patch_ready,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic          wbm_we_o,
    output logic [3:0]    wbm_sel_o,
    output logic [31:0]   wbm_adr_o,
    output logic [31:0]   wbm_dat_o,
    input  logic          wbm_ack_i,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [CW-1:0] patches_written
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_PATCH, WR_LO, GAP, WR_HI, FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [PW-1:0] patch_q, patch_d;
    logic [TW-1:0] beat_cnt_q, beat_cnt_d;
    logic          error_q, error_d;
    logic [CW-1:0] written_q, written_d;

    logic          in_beat;
    logic          hi_beat;
    logic [63:0]   patch_ext;
    logic [31:0]   word_adr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            patch_q     <= '0;
            beat_cnt_q  <= '0;
            error_q     <= 1'b0;
            written_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            patch_q     <= patch_d;
            beat_cnt_q  <= beat_cnt_d;
            error_q     <= error_d;
            written_q   <= written_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        patch_d     = patch_q;
        beat_cnt_d  = '0;
        error_d     = error_q;
        written_d   = written_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr_d  = start_addr;
                    remaining_d = num_patches;
                    error_d     = 1'b0;
                    written_d   = '0;
                    state_d     = (num_patches == '0) ? FINISH : WAIT_PATCH;
                end
            end
            WAIT_PATCH: begin
                if (patch_valid) begin
                    patch_d = patch_data;
                    state_d = WR_LO;
                end
            end
            WR_LO, WR_HI: begin
                if (wbm_ack_i) begin
                    if (state_q == WR_LO) begin
                        state_d = GAP;
                    end else begin
                        written_d   = written_q + CW'(1);
                        remaining_d = remaining_q - CW'(1);
                        cur_addr_d  = (cur_addr_q == AW'(NUM_QUERYS - 1)) ? '0
                                                                          : cur_addr_q + AW'(1);
                        state_d     = (remaining_q > CW'(1)) ? WAIT_PATCH : FINISH;
                    end
                end else if (beat_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Slave stalled: abandon the load, keep the completed count.
                    error_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    beat_cnt_d = beat_cnt_q + TW'(1);
                end
            end
            GAP:     state_d = WR_HI;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_beat   = (state_q == WR_LO) || (state_q == WR_HI);
    assign hi_beat   = (state_q == WR_HI);
    assign patch_ext = {{(64-PW){1'b0}}, patch_q};
    assign word_adr  = BASE_ADDR + ({{(32-AW){1'b0}}, cur_addr_q} << 1) + {31'b0, hi_beat};

    assign patch_ready     = (state_q == WAIT_PATCH);
    assign wbm_cyc_o       = in_beat || (state_q == GAP);
    assign wbm_stb_o       = in_beat;
    assign wbm_we_o        = in_beat;
    assign wbm_sel_o       = in_beat ? 4'hF : 4'h0;
    assign wbm_adr_o       = in_beat ? word_adr : 32'h0;
    assign wbm_dat_o       = !in_beat ? 32'h0 : (hi_beat ? patch_ext[63:32] : patch_ext[31:0]);
    assign busy            = (state_q != IDLE) && (state_q != FINISH);
    assign done            = (state_q == FINISH);
    assign error           = error_q;
    assign patches_written = written_q;

endmodule

// File: tb/tb_wbs_patch_loader.sv
// Randomized bench: a driver issues loads, a random-latency slave acks beats,
// and a monitor checks every acked beat against a queue of expected beats.
module tb_wbs_patch_loader;

    localparam int          NQ   = 408;
    localparam int          AW   = 9;
    localparam int          CW   = 10;
    localparam int          PW   = 55;
    localparam int          TO   = 8;
    localparam logic [31:0] BASE = 32'h3100_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [CW-1:0] num_patches = '0;
    logic          patch_valid = 1'b0;
    logic [PW-1:0] patch_data = '0;
    logic          patch_ready;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic [31:0]   wbm_adr_o, wbm_dat_o;
    logic          wbm_ack_i = 1'b0;
    logic          busy, done, error;
    logic [CW-1:0] patches_written;

    wbs_patch_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .num_patches(num_patches), .patch_valid(patch_valid), .patch_data(patch_data),
        .patch_ready(patch_ready), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .busy(busy), .done(done),
        .error(error), .patches_written(patches_written)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];   // {adr, dat} of each beat the slave should see acked
    int slave_mode = 0;      // 0 ack everything, 1 never ack, 2 ack lower beats only

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: patch k of a load lives at (start+k) mod NQ, two beats each.
    task automatic expect_patch(input int addr, input logic [PW-1:0] d);
        logic [63:0] full;
        logic [31:0] a;
        full = 64'(d);
        a = BASE + 32'(2 * addr);
        exp_q.push_back({a, full[31:0]});
        exp_q.push_back({a + 32'd1, full[63:32]});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Slave: random 0..3 cycle ack latency, decided just after each edge.
    always begin : slave
        int wcnt, lat;
        wcnt = 0;
        lat = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && wbm_stb_o && (slave_mode == 0 || (slave_mode == 2 && !wbm_adr_o[0]))) begin
                if (wcnt >= lat) begin
                    wbm_ack_i = 1'b1;
                    wcnt = 0;
                    lat = $urandom_range(0, 3);
                end else begin
                    wbm_ack_i = 1'b0;
                    wcnt++;
                end
            end else begin
                wbm_ack_i = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: beat contents, bus qualifiers, the gap cycle and accept->stb latency.
    always begin : monitor
        bit prev_lo_ack, prev_accept;
        logic [63:0] e;
        prev_lo_ack = 0;
        prev_accept = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_lo_ack = 0;
                prev_accept = 0;
            end else begin
                if (prev_lo_ack)
                    chk(!wbm_stb_o && wbm_cyc_o, "gap_cycle", {wbm_cyc_o, wbm_stb_o}, 2'b10);
                if (prev_accept)
                    chk(wbm_stb_o && !wbm_adr_o[0], "stb_after_accept", {wbm_stb_o, wbm_adr_o[0]}, 2'b10);
                if (patch_ready && wbm_stb_o)
                    chk(0, "stb_during_wait", 1, 0);
                if (wbm_stb_o && wbm_ack_i) begin
                    chk(wbm_cyc_o && wbm_we_o && wbm_sel_o == 4'hF, "bus_qual",
                        {wbm_cyc_o, wbm_we_o, wbm_sel_o}, 6'h3F);
                    if (exp_q.size() == 0) begin
                        chk(0, "unexpected_beat", {wbm_adr_o, wbm_dat_o}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(wbm_adr_o == e[63:32], "beat_adr", wbm_adr_o, e[63:32]);
                        chk(wbm_dat_o == e[31:0], "beat_dat", wbm_dat_o, e[31:0]);
                    end
                end
                prev_lo_ack = wbm_stb_o && wbm_ack_i && !wbm_adr_o[0];
                prev_accept = patch_valid && patch_ready;
            end
        end
    end

    task automatic do_start(input int sa, input int n);
        step();
        start = 1'b1;
        start_addr = AW'(sa);
        num_patches = CW'(n);
        step();
        start = 1'b0;
        chk(error == 1'b0, "error_cleared", error, 0);
        chk(patches_written == '0, "written_cleared", patches_written, 0);
        chk(busy == (n != 0), "busy_after_start", busy, n != 0);
    endtask

    task automatic send_patch(input logic [PW-1:0] d, input int idle);
        int cnt;
        repeat (idle) step();
        patch_valid = 1'b1;
        patch_data = d;
        cnt = 0;
        while (!patch_ready && cnt < 200) begin
            step();
            cnt++;
        end
        if (cnt >= 200) chk(0, "ready_timeout", 0, 1);
        step();
        patch_valid = 1'b0;
        patch_data = '0;
    endtask

    task automatic wait_done(input int n_exp, input bit err_exp);
        int cnt;
        cnt = 0;
        while (!done && cnt < 2000) begin
            step();
            cnt++;
        end
        chk(done == 1'b1, "done_pulse", done, 1);
        chk(busy == 1'b0, "busy_low_at_done", busy, 0);
        chk(patches_written == CW'(n_exp), "patches_written", patches_written, n_exp);
        chk(error == err_exp, "error_flag", error, err_exp);
        step();
        chk(done == 1'b0, "done_one_cycle", done, 0);
    endtask

    task automatic run_load(input int sa, input int n, input logic [PW-1:0] first,
                            input int first_idle, input bit poke_start);
        logic [PW-1:0] d;
        do_start(sa, n);
        for (int k = 0; k < n; k++) begin
            d = (k == 0 && first != '0) ? first : PW'({$urandom, $urandom});
            expect_patch((sa + k) % NQ, d);
            send_patch(d, (k == 0) ? first_idle : int'($urandom_range(0, 3)));
            if (poke_start && k == 0) begin
                start = 1'b1;
                start_addr = AW'($urandom_range(0, NQ - 1));
                num_patches = CW'($urandom_range(0, 7));
                step();
                start = 1'b0;
            end
        end
        wait_done(n, 1'b0);
    endtask

    initial begin : driver
        int cnt;
        repeat (3) step();
        chk({wbm_cyc_o, wbm_stb_o, busy, done, error, patch_ready} == 6'b0, "reset_outputs",
            {wbm_cyc_o, wbm_stb_o, busy, done, error, patch_ready}, 0);
        chk(patches_written == '0, "reset_written", patches_written, 0);
        rst_n = 1'b1;

        run_load(2, 1, 55'h00_1010_DEAD_BEEF, 0, 0);
        run_load(406, 3, '0, 1, 0);
        run_load($urandom_range(0, NQ - 1), 2, '0, 10, 0);
        run_load($urandom_range(0, NQ - 1), 4, '0, 2, 1);
        for (int i = 0; i < 6; i++)
            run_load($urandom_range(0, NQ - 1), $urandom_range(1, 5), '0, $urandom_range(0, 3), 0);

        // Zero-length load: done next cycle, no bus activity.
        do_start(17, 0);
        chk(done == 1'b1 && !wbm_cyc_o, "zero_count_done", {done, wbm_cyc_o}, 2'b10);
        step();

        // Stalled slave: stb held for exactly TO cycles, then abort with error.
        slave_mode = 1;
        do_start(5, 2);
        send_patch(PW'({$urandom, $urandom}), 0);
        cnt = 0;
        while (wbm_stb_o && cnt < 50) begin
            cnt++;
            step();
        end
        chk(cnt == TO, "timeout_stb_cycles", cnt, TO);
        chk(!wbm_cyc_o, "timeout_cyc_low", wbm_cyc_o, 0);
        wait_done(0, 1'b1);
        slave_mode = 0;
        run_load($urandom_range(0, NQ - 1), 1, '0, 0, 0);

        // Reset while the upper beat is on the bus.
        slave_mode = 2;
        begin
            logic [PW-1:0] d;
            logic [63:0] hi;
            d = PW'({$urandom, $urandom});
            do_start(100, 1);
            expect_patch(100, d);
            send_patch(d, 0);
            cnt = 0;
            while (!(wbm_stb_o && wbm_adr_o[0]) && cnt < 50) begin
                step();
                cnt++;
            end
            chk(wbm_stb_o && wbm_adr_o[0], "reached_hi_beat", wbm_stb_o, 1);
            hi = exp_q.pop_back();  // never acked
            rst_n = 1'b0;
            step();
            chk({wbm_cyc_o, wbm_stb_o, busy, done, error} == 5'b0, "reset_mid_beat",
                {wbm_cyc_o, wbm_stb_o, busy, done, error}, 0);
            chk(patches_written == '0 && !patch_ready, "reset_idle", {patches_written, patch_ready}, 0);
            rst_n = 1'b1;
            slave_mode = 0;
        end
        run_load(0, 2, '0, 0, 0);

        repeat (3) step();
        chk(exp_q.size() == 0, "all_beats_seen", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wbs_patch_loader.md
Name: wbs_patch_loader

Overview:
- Wishbone master that bulk-loads query patches into the query-patch memory behind the Wishbone slave controller.
- Sits directly upstream of the slave controller. Accepts PATCH_SIZE×DATA_WIDTH patches on a valid/ready stream.
- Each patch becomes two 32-bit Wishbone write beats, lower word then upper word, at BASE_ADDR + (addr<<1) + half.
- The patch address auto-increments, and a per-beat ack timeout flags a stalled slave.

Parameters:
- DATA_WIDTH, 11, bits per patch element
- PATCH_SIZE, 5, elements per patch (patch = 55 bits)
- ROW_SIZE, 24, query rows
- COL_SIZE, 17, query columns
- NUM_QUERYS, ROW_SIZE*COL_SIZE (408), number of query-memory entries
- BASE_ADDR, 32'h3100_0000, Wishbone query-memory window
- TIMEOUT_CYCLES, 255, maximum cycles to wait for ack per beat

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse that begins a load
- start_addr  in  $clog2(NUM_QUERYS)  first patch address
- num_patches  in  $clog2(NUM_QUERYS)+1  number of patches to write
- patch_valid  in  1  stream valid
- patch_data  in  PATCH_SIZE*DATA_WIDTH  patch payload
- patch_ready  out  1  stream ready
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  write enable (always 1 when stb is high)
- wbm_sel_o  out  4  byte select (4'hF)
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_ack_i  in  1  slave ack
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- error  out  1  timeout flag; sticky until the next accepted start or reset
- patches_written  out  $clog2(NUM_QUERYS)+1  patches fully acked in the current load

Behaviour:
- Reset (rst_n low at a clk edge) values:
  - all outputs 0; FSM goes to IDLE.
  - A reset mid-transaction drops cyc/stb on the following edge. No partial beat is retried.
- FSM states: IDLE, WAIT_PATCH, WR_LO, GAP, WR_HI, FINISH.
- IDLE:
  - start captures start_addr into cur_addr and num_patches into remaining. error clears, patches_written clears.
  - Next state is WAIT_PATCH, or FINISH if num_patches == 0.
- start while busy: ignored.
- WAIT_PATCH:
  - patch_ready = 1 only in this state.
  - On patch_valid && patch_ready, patch_data is registered and the FSM goes to WR_LO.
  - cyc/stb/we rise on the cycle after acceptance.
- WR_LO:
  - cyc = stb = we = 1, sel = 4'hF.
  - adr = BASE_ADDR + (cur_addr<<1) + 0; dat = patch[31:0].
  - All outputs stay stable until ack is sampled. On ack, go to GAP.
- GAP: stb = 0 for exactly one cycle, cyc stays 1, then go to WR_HI.
- WR_HI:
  - adr = BASE_ADDR + (cur_addr<<1) + 1.
  - dat = {9'b0, patch[54:32]} (upper bits zero-extended to 32).
- On the WR_HI ack (next cycle):
  - cyc = stb = 0.
  - patches_written increments and remaining decrements.
  - cur_addr increments; if cur_addr was NUM_QUERYS-1 it wraps to 0.
  - Next state is WAIT_PATCH if remaining > 0, else FINISH.
- FINISH: done = 1 for one cycle, busy drops in the same cycle, then go to IDLE.
- Timeout:
  - A beat counter clears when stb rises and increments each cycle stb is high without ack.
  - When the counter reaches TIMEOUT_CYCLES: cyc = stb = 0 on the next edge, error = 1, go to FINISH.
  - patches_written keeps its count of completed patches.
- An ack seen while stb = 0 (GAP, IDLE, WAIT_PATCH) is ignored.
- Throughput: the best case is 1 accept cycle + 2 single-cycle acks + 1 gap, i.e. 4 cycles per patch.

Test Plan:
- Single patch:
  - Stimulus: start_addr = 2, num_patches = 1, patch = 55'h00_1010_DEAD_BEEF, slave acks 1 cycle after stb.
  - Required: beat 1 adr = 32'h3100_0004, dat = 32'hDEAD_BEEF; beat 2 adr = 32'h3100_0005, dat = 32'h0000_1010; one stb-low GAP cycle between beats; done pulse; patches_written = 1; error = 0.
- Burst with wrap:
  - Stimulus: start_addr = 406, num_patches = 3.
  - Required: patch addresses 406, 407, 0, i.e. adr 32'h3100_032C, 32'h3100_032E, 32'h3100_0000 for the lower words; patches_written = 3.
- Backpressure:
  - Stimulus: patch_valid held low for 10 cycles, then high.
  - Required: patch_ready stays 1 in WAIT_PATCH; no stb during the wait; the write starts the cycle after acceptance.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 8, slave never acks.
  - Required: stb high for 8 cycles, then cyc/stb = 0, error = 1, done pulse, patches_written = 0. A following start clears error.
- Zero count and start-while-busy:
  - Stimulus: num_patches = 0.
  - Required: done on the next cycle with no Wishbone activity. A start pulse issued mid-load does not change cur_addr or remaining.
- Reset mid-beat:
  - Stimulus: rst_n low during WR_HI.
  - Required: cyc/stb/busy = 0 on the next edge and the FSM is in IDLE.
